time_adjust_ctrl: RTL and testbench
===================================

Name: time_adjust_ctrl

Overview:
Front-panel control FSM that turns debounced push-button levels into single-cycle enable pulses and a direction bit for the up/down modulo counters (clock minutes, clock hours, alarm minutes, alarm hours). It sits directly upstream of those counters and drives their en/upDown inputs. It also gates the normal time-keeping chain while a clock field is being adjusted. Direction convention: up_down=0 increments, up_down=1 decrements.

Parameters:
N_FIELDS, 4, number of adjustable fields; cnt_en width.
SEL_W, 2, width of field_sel; clog2(N_FIELDS).
REPEAT_DLY, 8, rep_tick strobes a button must be held before auto-repeat starts.
TIMEOUT, 32, rep_tick strobes with no button held before ADJUST exits to CLOCK.
CNT_W, 6, width of the internal repeat and idle counters; must hold max(REPEAT_DLY, TIMEOUT).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
rep_tick  in  1  one-cycle slow strobe (about 4 Hz) for auto-repeat and timeout timing.
btn_c  in  1  centre button, debounced and synchronous level; toggles mode.
btn_u  in  1  up button level.
btn_d  in  1  down button level.
btn_l  in  1  left button level; previous field.
btn_r  in  1  right button level; next field.
adj_mode  out  1  1 while in ADJUST.
field_sel  out  SEL_W  selected field. 0 = clock min, 1 = clock hr, 2 = alarm min, 3 = alarm hr.
cnt_en  out  N_FIELDS  one-hot, one-cycle counter enable pulse.
up_down  out  1  direction for counters; valid whenever cnt_en != 0.
clk_run  out  1  1 permits the normal time-keeping chain to advance.

Behaviour:
- Reset (asynchronous) forces:
  - state=CLOCK, adj_mode=0, field_sel=0, cnt_en=0, up_down=0, clk_run=1.
  - All edge-history registers, the repeat counter and the idle counter clear to 0.
- Rising-edge detection per button: rise = level & ~prev. prev is registered every clock. A button held through reset produces no rise until it is released and pressed again.
- All outputs are registered. cnt_en is high for exactly the one cycle following the first clk edge at which a qualifying rise or repeat event is sampled.
- States: CLOCK, ADJUST.
- CLOCK:
  - rise_c → ADJUST with field_sel=0.
  - U/D/L/R are ignored; cnt_en stays 0.
- ADJUST:
  - rise_c → CLOCK. field_sel returns to 0.
  - rise_r: field_sel+1, wrapping 3→0. rise_l: field_sel−1, wrapping 0→3.
  - rise_u alone: cnt_en[field_sel]=1 for one cycle, up_down=0.
  - rise_d alone: cnt_en[field_sel]=1 for one cycle, up_down=1.
  - btn_u and btn_d both high: no pulse, and the repeat counter is cleared.
- Priority for simultaneous events in one cycle: C > L/R > U/D. If rise_l and rise_r occur together, field_sel is unchanged. Lower-priority events in that cycle are dropped.
- Auto-repeat:
  - While exactly one of btn_u/btn_d is held in ADJUST, the repeat counter increments on each rep_tick, saturating at REPEAT_DLY.
  - Once it has reached REPEAT_DLY, every further rep_tick emits one pulse in the held direction.
  - Releasing the button, a field change, or leaving ADJUST clears the counter.
- Timeout:
  - In ADJUST, the idle counter increments on each rep_tick while all five button levels are 0.
  - Any button level high clears it.
  - On reaching TIMEOUT the block goes to CLOCK, sets field_sel=0 and clears the counter.
- clk_run = 0 only while state=ADJUST and field_sel∈{0,1}; otherwise 1. It is registered and updates in the same cycle as the state/field_sel change.
- up_down holds its last value between pulses.
- Reset asserted mid-pulse or mid-repeat: all outputs return to their reset values immediately, asynchronously.

Decomposition:
- Package time_adj_pkg holds:
  - state enum {CLOCK, ADJUST};
  - field indices F_CLK_MIN=0, F_CLK_HR=1, F_ALM_MIN=2, F_ALM_HR=3;
  - DIR_UP=0, DIR_DOWN=1.
- Sub-module btn_pulse_gen: edge detect plus auto-repeat for the U/D pair. Inputs are clk, rst, rep_tick, btn_u, btn_d and an enable. Outputs are a pulse and its direction.
- The top level holds the FSM, field select, idle timeout and output registers.

Test Plan:
1. Release reset with all buttons 0 → adj_mode=0, field_sel=0, cnt_en=0, up_down=0, clk_run=1. Then btn_u high for 10 cycles → cnt_en stays 0.
2. btn_c pulse, then btn_u press → adj_mode=1, clk_run=0, one cycle of cnt_en=4'b0001 with up_down=0. btn_d press → cnt_en=4'b0001 with up_down=1.
3. In ADJUST, btn_l once → field_sel=3, clk_run=1. btn_r twice → field_sel=1. Then btn_d → cnt_en=4'b0010, up_down=1.
4. In ADJUST at field 2, hold btn_u for 12 rep_ticks → one press pulse, none during rep_ticks 1–8, then one pulse per rep_tick, 4 pulses on cnt_en[2].
5. In ADJUST, no buttons for 32 rep_ticks → returns to CLOCK, field_sel=0, clk_run=1. Repeat with a button press at rep_tick 20 → still ADJUST at rep_tick 40.
6. btn_c and btn_u rise in the same cycle in ADJUST → CLOCK, no cnt_en. Assert rst while btn_u is held with auto-repeat active → all outputs reset at once, and no pulse after release of reset until btn_u is released and pressed again.

Source files
------------

// File: rtl/time_adj_pkg.sv
// time_adj_pkg: shared state, field index and direction constants for the time-adjust controller
package time_adj_pkg;
    typedef enum logic {CLOCK = 1'b0, ADJUST = 1'b1} state_t;
    localparam int F_CLK_MIN = 0;
    localparam int F_CLK_HR  = 1;
    localparam int F_ALM_MIN = 2;
    localparam int F_ALM_HR  = 3;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/time_adjust_ctrl_if.sv
// time_adjust_ctrl_if: front-panel button levels in, counter controls out
interface time_adjust_ctrl_if #(
    parameter int N_FIELDS = 4,
    parameter int SEL_W    = 2
);
    logic                rep_tick;
    logic                btn_c;
    logic                btn_u;
    logic                btn_d;
    logic                btn_l;
    logic                btn_r;
    logic                adj_mode;
    logic [SEL_W-1:0]    field_sel;
    logic [N_FIELDS-1:0] cnt_en;
    logic                up_down;
    logic                clk_run;
    modport master (
        output rep_tick, btn_c, btn_u, btn_d, btn_l, btn_r,
        input  adj_mode, field_sel, cnt_en, up_down, clk_run
    );
    modport slave (
        input  rep_tick, btn_c, btn_u, btn_d, btn_l, btn_r,
        output adj_mode, field_sel, cnt_en, up_down, clk_run
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: press-edge and auto-repeat pulse generation for the up/down button pair
module btn_pulse_gen
    import time_adj_pkg::*;
#(
    parameter int REPEAT_DLY = 8,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic rep_tick_i,
    input  logic btn_u_i,
    input  logic btn_d_i,
    input  logic en_i,
    output logic pulse_o,
    output logic dir_o
);
    logic [1:0]       rel_q;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             hold, rise, rpt;
    // released-history starts at 0 so a button held through reset needs a fresh press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_q <= '0;
            rep_q <= '0;
        end else begin
            rel_q <= {~btn_u_i, ~btn_d_i};
            rep_q <= rep_d;
        end
    end
    // exactly one of U/D held qualifies; repeat fires on ticks once the delay is reached
    always_comb begin
        hold    = en_i & (btn_u_i ^ btn_d_i);
        rise    = btn_u_i ? rel_q[1] : rel_q[0];
        rpt     = hold & rep_tick_i & (rep_q == CNT_W'(REPEAT_DLY));
        rep_d   = ~hold ? '0 : (rep_tick_i & ~rpt) ? rep_q + 1'b1 : rep_q;
        pulse_o = hold & (rise | rpt);
        dir_o   = btn_u_i ? DIR_UP : DIR_DOWN;
    end
endmodule

// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: mode FSM, field select and idle timeout driving the time/alarm counters
module time_adjust_ctrl
    import time_adj_pkg::*;
#(
    parameter int N_FIELDS   = 4,
    parameter int SEL_W      = 2,
    parameter int REPEAT_DLY = 8,
    parameter int TIMEOUT    = 32,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    time_adjust_ctrl_if.slave    io
);
    state_t              state_q, state_d;
    logic [2:0]          rel_q;
    logic [CNT_W-1:0]    idle_q, idle_d;
    logic [SEL_W-1:0]    field_q, field_d;
    logic [N_FIELDS-1:0] cnt_en_q, cnt_en_d;
    logic                adj_q, adj_d, ud_q, ud_d, run_q, run_d;
    logic                rise_c, rise_l, rise_r, any_btn, timeout, sub_en, pulse, dir;

    assign rise_c  = io.btn_c & rel_q[2];
    assign rise_l  = io.btn_l & rel_q[1];
    assign rise_r  = io.btn_r & rel_q[0];
    assign any_btn = io.btn_c | io.btn_u | io.btn_d | io.btn_l | io.btn_r;
    assign timeout = (state_q == ADJUST) & ~any_btn & io.rep_tick & (idle_q == CNT_W'(TIMEOUT - 1));
    assign sub_en  = (state_q == ADJUST) & ~(rise_c | rise_l | rise_r);

    btn_pulse_gen #(
        .REPEAT_DLY (REPEAT_DLY),
        .CNT_W      (CNT_W)
    ) u_ud (
        .clk        (clk),
        .rst        (rst),
        .rep_tick_i (io.rep_tick),
        .btn_u_i    (io.btn_u),
        .btn_d_i    (io.btn_d),
        .en_i       (sub_en),
        .pulse_o    (pulse),
        .dir_o      (dir)
    );

    // mode state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CLOCK;
        else     state_q <= state_d;
    end
    // centre press toggles mode; an idle timeout also drops back to CLOCK
    always_comb begin
        state_d = (state_q == CLOCK) ? (rise_c ? ADJUST : CLOCK) : ((rise_c | timeout) ? CLOCK : ADJUST);
    end
    // next values of field, idle counter and all registered outputs
    always_comb begin
        field_d  = (state_q != ADJUST || state_d != ADJUST) ? SEL_W'(F_CLK_MIN)
                 : (rise_l & ~rise_r) ? ((field_q == '0) ? SEL_W'(N_FIELDS - 1) : field_q - 1'b1)
                 : (rise_r & ~rise_l) ? ((field_q == SEL_W'(N_FIELDS - 1)) ? '0 : field_q + 1'b1)
                 : field_q;
        idle_d   = (state_q != ADJUST || any_btn || timeout) ? '0 : io.rep_tick ? idle_q + 1'b1 : idle_q;
        cnt_en_d = pulse ? N_FIELDS'(1) << field_q : '0;
        ud_d     = pulse ? dir : ud_q;
        adj_d    = (state_d == ADJUST);
        run_d    = ~(adj_d & (field_d <= SEL_W'(F_CLK_HR)));
    end
    // edge history, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_q    <= '0;
            idle_q   <= '0;
            field_q  <= '0;
            cnt_en_q <= '0;
            adj_q    <= 1'b0;
            ud_q     <= 1'b0;
            run_q    <= 1'b1;
        end else begin
            rel_q    <= {~io.btn_c, ~io.btn_l, ~io.btn_r};
            idle_q   <= idle_d;
            field_q  <= field_d;
            cnt_en_q <= cnt_en_d;
            adj_q    <= adj_d;
            ud_q     <= ud_d;
            run_q    <= run_d;
        end
    end

    assign io.adj_mode  = adj_q;
    assign io.field_sel = field_q;
    assign io.cnt_en    = cnt_en_q;
    assign io.up_down   = ud_q;
    assign io.clk_run   = run_q;
endmodule

// File: tb/tb_time_adjust_ctrl.sv
// tb_time_adjust_ctrl: directed and random stimulus against a cycle-level behavioural model
module tb_time_adjust_ctrl;
    localparam int RD = 8;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;

    bit   m_adj, m_ud;
    int   m_field, m_en, m_rep, m_idle;
    bit   armed [5];

    time_adjust_ctrl_if #(.N_FIELDS(4), .SEL_W(2)) bus ();

    time_adjust_ctrl #(
        .N_FIELDS   (4),
        .SEL_W      (2),
        .REPEAT_DLY (RD),
        .TIMEOUT    (TO),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_b(input bit c, input bit u, input bit d, input bit l, input bit r);
        bus.btn_c = c;
        bus.btn_u = u;
        bus.btn_d = d;
        bus.btn_l = l;
        bus.btn_r = r;
    endtask

    task automatic m_reset();
        m_adj = 0; m_ud = 0; m_field = 0; m_en = 0; m_rep = 0; m_idle = 0;
        for (int i = 0; i < 5; i++) armed[i] = 0;
    endtask

    // one clock of the panel rules: button order c,u,d,l,r
    task automatic m_step(input bit tick);
        bit lv [5];
        bit rs [5];
        bit fire;
        lv = '{bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r};
        for (int i = 0; i < 5; i++) begin
            rs[i] = lv[i] && armed[i];
            armed[i] = !lv[i];
        end
        m_en = 0;
        if (!m_adj) begin
            m_rep = 0; m_idle = 0;
            if (rs[0]) begin m_adj = 1; m_field = 0; end
        end else if (rs[0]) begin
            m_adj = 0; m_field = 0; m_rep = 0; m_idle = 0;
        end else if (rs[3] || rs[4]) begin
            if (rs[3] && !rs[4]) m_field = (m_field + 3) % 4;
            if (rs[4] && !rs[3]) m_field = (m_field + 1) % 4;
            m_rep = 0; m_idle = 0;
        end else begin
            if (lv[1] != lv[2]) begin
                fire = lv[1] ? rs[1] : rs[2];
                if (tick) begin
                    if (m_rep >= RD) fire = 1;
                    else m_rep++;
                end
                if (fire) begin m_en = 1 << m_field; m_ud = lv[2]; end
            end else m_rep = 0;
            if (lv[0] | lv[1] | lv[2] | lv[3] | lv[4]) m_idle = 0;
            else if (tick) begin
                m_idle++;
                if (m_idle >= TO) begin m_adj = 0; m_field = 0; m_idle = 0; end
            end
        end
    endtask

    task automatic chk_model();
        chk("adj_mode", bus.adj_mode, m_adj);
        chk("field_sel", bus.field_sel, m_field);
        chk("cnt_en", bus.cnt_en, m_en);
        chk("up_down", bus.up_down, m_ud);
        chk("clk_run", bus.clk_run, !(m_adj && m_field < 2));
    endtask

    task automatic cyc(input bit tick);
        bus.rep_tick = tick;
        @(posedge clk);
        m_step(tick);
        #1;
        chk_model();
        if (bus.cnt_en != 0) pulses++;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin cyc(1); cyc(0); end
    endtask

    task automatic do_rst();
        rst = 1'b1;
        #1;
        m_reset();
        chk_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.rep_tick = 0;
        set_b(0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_adj", bus.adj_mode, 0);
        chk("rst_field", bus.field_sel, 0);
        chk("rst_cnt_en", bus.cnt_en, 0);
        chk("rst_up_down", bus.up_down, 0);
        chk("rst_clk_run", bus.clk_run, 1);
        rst = 1'b0;
        // 1: up held in CLOCK does nothing
        set_b(0, 1, 0, 0, 0);
        repeat (10) begin cyc(0); chk("t1_no_en", bus.cnt_en, 0); end
        set_b(0, 0, 0, 0, 0); cyc(0);
        // 2: enter ADJUST, up then down on clock minutes
        set_b(1, 0, 0, 0, 0); cyc(0);
        chk("t2_adj", bus.adj_mode, 1);
        chk("t2_run", bus.clk_run, 0);
        set_b(0, 0, 0, 0, 0); cyc(0);
        set_b(0, 1, 0, 0, 0); cyc(0);
        chk("t2_up_en", bus.cnt_en, 4'b0001);
        chk("t2_up_dir", bus.up_down, 0);
        set_b(0, 0, 0, 0, 0); cyc(0);
        chk("t2_one_cycle", bus.cnt_en, 0);
        set_b(0, 0, 1, 0, 0); cyc(0);
        chk("t2_dn_en", bus.cnt_en, 4'b0001);
        chk("t2_dn_dir", bus.up_down, 1);
        set_b(0, 0, 0, 0, 0); cyc(0);
        // 3: field navigation with wrap
        set_b(0, 0, 0, 1, 0); cyc(0);
        chk("t3_wrap_l", bus.field_sel, 3);
        chk("t3_run", bus.clk_run, 1);
        set_b(0, 0, 0, 0, 0); cyc(0);
        repeat (2) begin set_b(0, 0, 0, 0, 1); cyc(0); set_b(0, 0, 0, 0, 0); cyc(0); end
        chk("t3_field1", bus.field_sel, 1);
        set_b(0, 0, 1, 0, 0); cyc(0);
        chk("t3_hr_en", bus.cnt_en, 4'b0010);
        chk("t3_hr_dir", bus.up_down, 1);
        set_b(0, 0, 0, 0, 0); cyc(0);
        // 4: auto-repeat on alarm minutes
        set_b(0, 0, 0, 0, 1); cyc(0); set_b(0, 0, 0, 0, 0); cyc(0);
        chk("t4_field2", bus.field_sel, 2);
        pulses = 0;
        set_b(0, 1, 0, 0, 0); cyc(0);
        repeat (12) begin cyc(0); cyc(0); cyc(0); cyc(1); end
        chk("t4_pulses", pulses, 5);
        set_b(0, 0, 0, 0, 0); cyc(0);
        // 5: idle timeout, and a press restarting it
        ticks(TO - 1);
        chk("t5_before_to", bus.adj_mode, 1);
        cyc(1);
        chk("t5_to_adj", bus.adj_mode, 0);
        chk("t5_to_field", bus.field_sel, 0);
        chk("t5_to_run", bus.clk_run, 1);
        set_b(1, 0, 0, 0, 0); cyc(0); set_b(0, 0, 0, 0, 0); cyc(0);
        ticks(20);
        set_b(0, 1, 0, 0, 0); cyc(0); set_b(0, 0, 0, 0, 0); cyc(0);
        ticks(20);
        chk("t5_still_adj", bus.adj_mode, 1);
        // 6: centre beats up in the same cycle
        set_b(1, 1, 0, 0, 0); cyc(0);
        chk("t6_cu_adj", bus.adj_mode, 0);
        chk("t6_cu_en", bus.cnt_en, 0);
        set_b(0, 0, 0, 0, 0); cyc(0);
        // 6: reset during active down auto-repeat
        set_b(1, 0, 0, 0, 0); cyc(0); set_b(0, 0, 0, 0, 0); cyc(0);
        set_b(0, 0, 1, 0, 0); cyc(0);
        repeat (10) begin cyc(0); cyc(1); end
        chk("t6_rep_en", bus.cnt_en, 4'b0001);
        chk("t6_rep_dir", bus.up_down, 1);
        do_rst();
        chk("t6_rst_en", bus.cnt_en, 0);
        chk("t6_rst_dir", bus.up_down, 0);
        pulses = 0;
        ticks(20);
        chk("t6_no_pulse", pulses, 0);
        set_b(0, 0, 0, 0, 0); cyc(0);
        set_b(1, 0, 0, 0, 0); cyc(0); set_b(0, 0, 0, 0, 0); cyc(0);
        set_b(0, 0, 1, 0, 0); cyc(0);
        chk("t6_repress_en", bus.cnt_en, 4'b0001);
        chk("t6_repress_dir", bus.up_down, 1);
        set_b(0, 0, 0, 0, 0); cyc(0);
        // random button activity against the model
        repeat (4000) begin
            if ($urandom_range(0, 59) == 0) bus.btn_c = ~bus.btn_c;
            if ($urandom_range(0, 5) == 0) bus.btn_u = ~bus.btn_u;
            if ($urandom_range(0, 5) == 0) bus.btn_d = ~bus.btn_d;
            if ($urandom_range(0, 9) == 0) bus.btn_l = ~bus.btn_l;
            if ($urandom_range(0, 9) == 0) bus.btn_r = ~bus.btn_r;
            if ($urandom_range(0, 599) == 0) do_rst();
            else cyc($urandom_range(0, 3) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
